// File: rtl/pc_region_profiler.sv
// Multi-channel PC-region profiler fed from the write-back stage, read over a request/valid port.
// Define PROF_MAX_LAT_EN to add per-channel max single-invocation latency tracking (rd_sel 3).
module pc_region_profiler #(
  parameter int XLEN  = 32,
  parameter int N_CH  = 8,
  parameter int CNT_W = 32,
  parameter int ACC_W = 48,
  parameter logic [XLEN-1:0] START_PC = 32'h0,
  parameter logic [XLEN-1:0] STOP_PC  = 32'h0,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            stall_i,
  input  logic [XLEN-1:0] wbk_pc_i,
  input  logic            cfg_we_i,
  input  logic [CH_W-1:0] cfg_ch_i,
  input  logic [1:0]      cfg_sel_i,
  input  logic [XLEN-1:0] cfg_data_i,
  input  logic [N_CH-1:0] ch_en_i,
  input  logic            clr_i,
  input  logic            rd_req_i,
  input  logic [CH_W-1:0] rd_ch_i,
  input  logic [1:0]      rd_sel_i,
  output logic            rd_valid_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic            run_o,
  output logic [N_CH-1:0] ovf_o,
  output logic [N_CH-1:0] overlap_o
);

  localparam logic [CH_W:0] N_CH_L = (CH_W+1)'(N_CH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e state_r, state_nxt_s;
  logic   run_r;

  logic [XLEN-1:0]            start_pc_r, stop_pc_r;
  logic [N_CH-1:0][XLEN-1:0]  entry_pc_r, exit_pc_r;

  logic [N_CH-1:0]            active_r, active_nxt_s;
  logic [N_CH-1:0]            ovf_r, ovf_nxt_s;
  logic [N_CH-1:0]            ovl_r, ovl_nxt_s;
  logic [N_CH-1:0][CNT_W-1:0] count_r, count_nxt_s;
  logic [N_CH-1:0][ACC_W-1:0] cycles_r, cycles_nxt_s;
`ifdef PROF_MAX_LAT_EN
  logic [N_CH-1:0][ACC_W-1:0] lat_r, lat_nxt_s;
  logic [N_CH-1:0][ACC_W-1:0] max_r, max_nxt_s;
  logic [ACC_W-1:0]           lat_inc_s;
`endif

  logic            ret_s, start_hit_s, stop_hit_s, in_run_s;
  logic [N_CH-1:0] entry_hit_s, exit_hit_s;

  logic            rd_valid_r;
  logic [XLEN-1:0] rd_data_r, rd_mux_s;

  // PC match decode against the current configuration.
  always_comb begin
    ret_s       = !stall_i;
    start_hit_s = ret_s && (wbk_pc_i == start_pc_r);
    stop_hit_s  = ret_s && (wbk_pc_i == stop_pc_r);
    in_run_s    = (state_r == ST_RUN);
    for (int c = 0; c < N_CH; c++) begin
      entry_hit_s[c] = ret_s && (wbk_pc_i == entry_pc_r[c]);
      exit_hit_s[c]  = ret_s && (wbk_pc_i == exit_pc_r[c]);
    end
  end

  // Window FSM next state; a stop in RUN beats a simultaneous start.
  always_comb begin
    state_nxt_s = state_r;
    if (clr_i) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: if (start_hit_s) state_nxt_s = ST_RUN;  else state_nxt_s = ST_IDLE;
        ST_RUN:  if (stop_hit_s)  state_nxt_s = ST_DONE; else state_nxt_s = ST_RUN;
        ST_DONE: if (start_hit_s) state_nxt_s = ST_RUN;  else state_nxt_s = ST_DONE;
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Window FSM state and registered run flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
      run_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      run_r   <= (state_nxt_s == ST_RUN);
    end
  end

  // Per-channel activity, saturating counters and sticky flags.
  always_comb begin
    active_nxt_s = active_r;
    ovf_nxt_s    = ovf_r;
    ovl_nxt_s    = ovl_r;
    count_nxt_s  = count_r;
    cycles_nxt_s = cycles_r;
`ifdef PROF_MAX_LAT_EN
    lat_nxt_s    = lat_r;
    max_nxt_s    = max_r;
    lat_inc_s    = {ACC_W{1'b0}};
`endif
    for (int c = 0; c < N_CH; c++) begin
      if (in_run_s && active_r[c]) begin
        if (cycles_r[c] == {ACC_W{1'b1}}) ovf_nxt_s[c] = 1'b1;
        else cycles_nxt_s[c] = cycles_r[c] + ACC_W'(1'b1);
      end else begin
        cycles_nxt_s[c] = cycles_r[c];
      end

      if (!ch_en_i[c]) begin
        active_nxt_s[c] = 1'b0;
      end else if (active_r[c]) begin
        // Exit wins over a coinciding entry while the region is open.
        if (exit_hit_s[c]) active_nxt_s[c] = 1'b0;
        else if (entry_hit_s[c]) ovl_nxt_s[c] = 1'b1;
        else active_nxt_s[c] = 1'b1;
      end else if (entry_hit_s[c]) begin
        active_nxt_s[c] = 1'b1;
        if (in_run_s) begin
          if (count_r[c] == {CNT_W{1'b1}}) ovf_nxt_s[c] = 1'b1;
          else count_nxt_s[c] = count_r[c] + CNT_W'(1'b1);
        end else begin
          count_nxt_s[c] = count_r[c];
        end
      end else begin
        active_nxt_s[c] = 1'b0;
      end

`ifdef PROF_MAX_LAT_EN
      if (lat_r[c] == {ACC_W{1'b1}}) lat_inc_s = lat_r[c];
      else lat_inc_s = lat_r[c] + ACC_W'(1'b1);
      if (in_run_s && ch_en_i[c] && active_r[c] && exit_hit_s[c] && (lat_inc_s > max_r[c])) begin
        max_nxt_s[c] = lat_inc_s;
      end else begin
        max_nxt_s[c] = max_r[c];
      end
      if (ch_en_i[c] && !active_r[c] && entry_hit_s[c]) lat_nxt_s[c] = {ACC_W{1'b0}};
      else if (in_run_s && active_r[c]) lat_nxt_s[c] = lat_inc_s;
      else lat_nxt_s[c] = lat_r[c];
`endif
    end
  end

  // Channel state registers; clr_i wipes everything except configuration.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_r <= {N_CH{1'b0}};
      ovf_r    <= {N_CH{1'b0}};
      ovl_r    <= {N_CH{1'b0}};
      count_r  <= {(N_CH*CNT_W){1'b0}};
      cycles_r <= {(N_CH*ACC_W){1'b0}};
`ifdef PROF_MAX_LAT_EN
      lat_r    <= {(N_CH*ACC_W){1'b0}};
      max_r    <= {(N_CH*ACC_W){1'b0}};
`endif
    end else if (clr_i) begin
      active_r <= {N_CH{1'b0}};
      ovf_r    <= {N_CH{1'b0}};
      ovl_r    <= {N_CH{1'b0}};
      count_r  <= {(N_CH*CNT_W){1'b0}};
      cycles_r <= {(N_CH*ACC_W){1'b0}};
`ifdef PROF_MAX_LAT_EN
      lat_r    <= {(N_CH*ACC_W){1'b0}};
      max_r    <= {(N_CH*ACC_W){1'b0}};
`endif
    end else begin
      active_r <= active_nxt_s;
      ovf_r    <= ovf_nxt_s;
      ovl_r    <= ovl_nxt_s;
      count_r  <= count_nxt_s;
      cycles_r <= cycles_nxt_s;
`ifdef PROF_MAX_LAT_EN
      lat_r    <= lat_nxt_s;
      max_r    <= max_nxt_s;
`endif
    end
  end

  // Configuration registers; start/stop are global and ignore the channel field.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      start_pc_r <= START_PC;
      stop_pc_r  <= STOP_PC;
      entry_pc_r <= {(N_CH*XLEN){1'b0}};
      exit_pc_r  <= {(N_CH*XLEN){1'b0}};
    end else if (cfg_we_i) begin
      case (cfg_sel_i)
        2'd0: if ({1'b0, cfg_ch_i} < N_CH_L) entry_pc_r[cfg_ch_i] <= cfg_data_i;
        2'd1: if ({1'b0, cfg_ch_i} < N_CH_L) exit_pc_r[cfg_ch_i]  <= cfg_data_i;
        2'd2: start_pc_r <= cfg_data_i;
        2'd3: stop_pc_r  <= cfg_data_i;
        default: start_pc_r <= start_pc_r;
      endcase
    end
  end

  // Read-port data select from the pre-edge counter values.
  always_comb begin
    rd_mux_s = {XLEN{1'b0}};
    if ({1'b0, rd_ch_i} < N_CH_L) begin
      case (rd_sel_i)
        2'd0: rd_mux_s = XLEN'(count_r[rd_ch_i]);
        2'd1: rd_mux_s = cycles_r[rd_ch_i][XLEN-1:0];
        2'd2: rd_mux_s = XLEN'(cycles_r[rd_ch_i][ACC_W-1:XLEN]);
`ifdef PROF_MAX_LAT_EN
        2'd3: rd_mux_s = max_r[rd_ch_i][XLEN-1:0];
`else
        2'd3: rd_mux_s = {XLEN{1'b0}};
`endif
        default: rd_mux_s = {XLEN{1'b0}};
      endcase
    end else begin
      rd_mux_s = {XLEN{1'b0}};
    end
  end

  // Registered read response; data holds between requests.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_valid_r <= 1'b0;
      rd_data_r  <= {XLEN{1'b0}};
    end else begin
      rd_valid_r <= rd_req_i;
      if (rd_req_i) rd_data_r <= rd_mux_s;
    end
  end

  assign rd_valid_o = rd_valid_r;
  assign rd_data_o  = rd_data_r;
  assign run_o      = run_r;
  assign ovf_o      = ovf_r;
  assign overlap_o  = ovl_r;

endmodule

// File: tb/tb_pc_region_profiler.sv
// Self-checking bench for pc_region_profiler: directed scenarios plus random traffic
// compared every cycle against a behavioural model (two instances: CNT_W=32 and CNT_W=4).
module tb_pc_region_profiler;

  localparam int N = 8;
  localparam logic [31:0] IDLE_PC = 32'h4;
  localparam longint unsigned ACC_MAX = (64'd1 << 48) - 64'd1;
  localparam longint unsigned CNT_MAX = 64'hFFFF_FFFF;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        stall;
  logic [31:0] wbk_pc;
  logic        cfg_we;
  logic [2:0]  cfg_ch;
  logic [1:0]  cfg_sel;
  logic [31:0] cfg_data;
  logic [7:0]  ch_en;
  logic        clr;
  logic        rd_req;
  logic [2:0]  rd_ch;
  logic [1:0]  rd_sel;

  logic        rd_valid, run, rd_valid4, run4;
  logic [31:0] rd_data, rd_data4;
  logic [7:0]  ovf, ovl, ovf4, ovl4;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // behavioural model state
  bit              m_run;
  logic [31:0]     m_start, m_stop;
  logic [31:0]     m_entry [N];
  logic [31:0]     m_exit  [N];
  bit              m_act [N];
  bit              m_ovf [N];
  bit              m_ovf4[N];
  bit              m_ovl [N];
  longint unsigned m_cnt [N];
  longint unsigned m_cnt4[N];
  longint unsigned m_cyc [N];
  longint unsigned m_lat [N];
  longint unsigned m_max [N];
  bit              m_rv;
  logic [31:0]     m_rd, m_rd4;

  pc_region_profiler u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .stall_i(stall), .wbk_pc_i(wbk_pc),
    .cfg_we_i(cfg_we), .cfg_ch_i(cfg_ch), .cfg_sel_i(cfg_sel), .cfg_data_i(cfg_data),
    .ch_en_i(ch_en), .clr_i(clr), .rd_req_i(rd_req), .rd_ch_i(rd_ch), .rd_sel_i(rd_sel),
    .rd_valid_o(rd_valid), .rd_data_o(rd_data), .run_o(run), .ovf_o(ovf), .overlap_o(ovl)
  );

  pc_region_profiler #(.CNT_W(4)) u_dut4 (
    .clk_i(clk_i), .rst_ni(rst_ni), .stall_i(stall), .wbk_pc_i(wbk_pc),
    .cfg_we_i(cfg_we), .cfg_ch_i(cfg_ch), .cfg_sel_i(cfg_sel), .cfg_data_i(cfg_data),
    .ch_en_i(ch_en), .clr_i(clr), .rd_req_i(rd_req), .rd_ch_i(rd_ch), .rd_sel_i(rd_sel),
    .rd_valid_o(rd_valid4), .rd_data_o(rd_data4), .run_o(run4), .ovf_o(ovf4), .overlap_o(ovl4)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rd_val(input int ch, input int sel, input bit narrow);
    case (sel)
      0: return narrow ? 32'(m_cnt4[ch]) : 32'(m_cnt[ch]);
      1: return 32'(m_cyc[ch]);
      2: return 32'(m_cyc[ch] >> 32);
`ifdef PROF_MAX_LAT_EN
      default: return 32'(m_max[ch]);
`else
      default: return 32'h0;
`endif
    endcase
  endfunction

  function automatic logic [7:0] pack(input bit v [N]);
    logic [7:0] r;
    for (int i = 0; i < N; i++) r[i] = v[i];
    return r;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < N; c++) begin
      m_act[c] = 0; m_ovf[c] = 0; m_ovf4[c] = 0; m_ovl[c] = 0;
      m_cnt[c] = 0; m_cnt4[c] = 0; m_cyc[c] = 0; m_lat[c] = 0; m_max[c] = 0;
    end
    m_run = 0;
  endtask

  task automatic model_reset();
    model_clear();
    m_start = 32'h0; m_stop = 32'h0;
    for (int c = 0; c < N; c++) begin m_entry[c] = 32'h0; m_exit[c] = 32'h0; end
    m_rv = 0; m_rd = 32'h0; m_rd4 = 32'h0;
  endtask

  // One clock of the profiler, applied from the inputs present at the edge.
  task automatic model_step();
    bit ret, ent, ext;
    ret  = !stall;
    m_rv = rd_req;
    if (rd_req) begin
      m_rd  = rd_val(int'(rd_ch), int'(rd_sel), 1'b0);
      m_rd4 = rd_val(int'(rd_ch), int'(rd_sel), 1'b1);
    end
    if (clr) begin
      model_clear();
    end else begin
      for (int c = 0; c < N; c++) begin
        ent = ret && (wbk_pc == m_entry[c]);
        ext = ret && (wbk_pc == m_exit[c]);
        if (m_run && ch_en[c] && m_act[c] && ext && (m_lat[c] + 1 > m_max[c])) m_max[c] = m_lat[c] + 1;
        if (m_run && m_act[c]) begin
          if (m_cyc[c] == ACC_MAX) begin m_ovf[c] = 1; m_ovf4[c] = 1; end
          else m_cyc[c]++;
          m_lat[c]++;
        end
        if (!ch_en[c]) m_act[c] = 0;
        else if (m_act[c]) begin
          if (ext) m_act[c] = 0;
          else if (ent) m_ovl[c] = 1;
        end else if (ent) begin
          m_act[c] = 1;
          m_lat[c] = 0;
          if (m_run) begin
            if (m_cnt[c] == CNT_MAX) m_ovf[c] = 1; else m_cnt[c]++;
            if (m_cnt4[c] == 15) m_ovf4[c] = 1; else m_cnt4[c]++;
          end
        end
      end
      if (m_run) begin
        if (ret && wbk_pc == m_stop) m_run = 0;
      end else if (ret && wbk_pc == m_start) begin
        m_run = 1;
      end
    end
    if (cfg_we) begin
      case (cfg_sel)
        2'd0: m_entry[cfg_ch] = cfg_data;
        2'd1: m_exit[cfg_ch]  = cfg_data;
        2'd2: m_start = cfg_data;
        default: m_stop = cfg_data;
      endcase
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    if (rst_ni) model_step();
    @(negedge clk_i);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic retire(input logic [31:0] pc);
    wbk_pc = pc; stall = 1'b0;
    cyc();
    wbk_pc = IDLE_PC;
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [2:0] ch, input logic [31:0] d);
    cfg_we = 1'b1; cfg_sel = sel; cfg_ch = ch; cfg_data = d;
    cyc();
    cfg_we = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1; cyc(); clr = 1'b0;
  endtask

  task automatic read_chk(input string nm, input int ch, input int sel, input logic [31:0] exp);
    rd_req = 1'b1; rd_ch = 3'(ch); rd_sel = 2'(sel);
    cyc();
    rd_req = 1'b0;
    chk(nm, {32'h0, rd_data}, {32'h0, exp});
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk_i) begin
    if (chk_en && rst_ni) begin
      chk("run",      {63'h0, run},       {63'h0, m_run});
      chk("ovf",      {56'h0, ovf},       {56'h0, pack(m_ovf)});
      chk("overlap",  {56'h0, ovl},       {56'h0, pack(m_ovl)});
      chk("rd_valid", {63'h0, rd_valid},  {63'h0, m_rv});
      chk("rd_data",  {32'h0, rd_data},   {32'h0, m_rd});
      chk("run4",     {63'h0, run4},      {63'h0, m_run});
      chk("ovf4",     {56'h0, ovf4},      {56'h0, pack(m_ovf4)});
      chk("overlap4", {56'h0, ovl4},      {56'h0, pack(m_ovl)});
      chk("rd_valid4",{63'h0, rd_valid4}, {63'h0, m_rv});
      chk("rd_data4", {32'h0, rd_data4},  {32'h0, m_rd4});
    end
  end

  initial begin
    logic [31:0] burst_exp [3];
    int r;
    rst_ni = 1'b0; stall = 1'b0; wbk_pc = IDLE_PC; cfg_we = 1'b0; cfg_ch = 3'd0;
    cfg_sel = 2'd0; cfg_data = 32'h0; ch_en = 8'hFF; clr = 1'b0; rd_req = 1'b0;
    rd_ch = 3'd0; rd_sel = 2'd0;
    model_reset();
    repeat (2) @(negedge clk_i);
    chk("reset_run", {63'h0, run}, 64'h0);
    chk("reset_rv", {63'h0, rd_valid}, 64'h0);
    chk("reset_rd", {32'h0, rd_data}, 64'h0);
    chk("reset_flags", {48'h0, ovf, ovl}, 64'h0);
    rst_ni = 1'b1;
    chk_en = 1'b1;

    // basic region: entry at 0x100, exit five cycles later
    cfg_write(2'd0, 3'd0, 32'h100);
    cfg_write(2'd1, 3'd0, 32'h140);
    cfg_write(2'd2, 3'd5, 32'h10);
    cfg_write(2'd3, 3'd5, 32'h20);
    retire(32'h10);
    retire(32'h100);
    idle(4);
    retire(32'h140);
    chk("t1_run", {63'h0, run}, 64'h1);
    burst_exp[0] = 32'd1; burst_exp[1] = 32'd5; burst_exp[2] = 32'd0;
    rd_req = 1'b1; rd_ch = 3'd0;
    for (int s = 0; s < 3; s++) begin
      rd_sel = 2'(s);
      cyc();
      chk("burst_valid", {63'h0, rd_valid}, 64'h1);
      chk("burst_data", {32'h0, rd_data}, {32'h0, burst_exp[s]});
    end
    rd_req = 1'b0;
    cyc();
    chk("burst_end_valid", {63'h0, rd_valid}, 64'h0);
    chk("burst_hold", {32'h0, rd_data}, 64'h0);

    // stalled entry matches are not retirements
    do_clr();
    retire(32'h10);
    wbk_pc = 32'h100; stall = 1'b1;
    idle(3);
    stall = 1'b0;
    cyc();
    wbk_pc = IDLE_PC;
    idle(2);
    retire(32'h140);
    read_chk("stall_count", 0, 0, 32'd1);
    read_chk("stall_cycles", 0, 1, 32'd3);

    // re-entry while active, then clear
    do_clr();
    retire(32'h10);
    retire(32'h100);
    retire(32'h100);
    chk("ovl_set", {56'h0, ovl}, 64'h1);
    read_chk("ovl_count", 0, 0, 32'd1);
    do_clr();
    chk("clr_ovl", {56'h0, ovl}, 64'h0);
    chk("clr_run", {63'h0, run}, 64'h0);
    read_chk("clr_count", 0, 0, 32'd0);
    read_chk("clr_cycles", 0, 1, 32'd0);

    // window gating and restart from DONE
    retire(32'h100); retire(IDLE_PC); retire(32'h140);
    read_chk("pre_start", 0, 0, 32'd0);
    retire(32'h10);
    retire(32'h100); retire(IDLE_PC); retire(32'h140);
    retire(32'h20);
    chk("done_run", {63'h0, run}, 64'h0);
    retire(32'h100); retire(IDLE_PC); retire(32'h140);
    read_chk("post_stop", 0, 0, 32'd1);
    retire(32'h10);
    chk("restart_run", {63'h0, run}, 64'h1);
    retire(32'h100); retire(IDLE_PC); retire(32'h140);
    read_chk("resume_count", 0, 0, 32'd2);
    read_chk("resume_cycles", 0, 1, 32'd4);

    // counter saturation on the 4-bit instance
    do_clr();
    retire(32'h10);
    for (int i = 0; i < 16; i++) begin retire(32'h100); retire(32'h140); end
    read_chk("sat_count32", 0, 0, 32'd16);
    chk("sat_count4", {32'h0, rd_data4}, 64'd15);
    chk("sat_ovf4", {56'h0, ovf4}, 64'h1);
    chk("sat_ovf32", {56'h0, ovf}, 64'h0);

    // latencies 3, 9, 4
    do_clr();
    retire(32'h10);
    for (int i = 0; i < 3; i++) begin
      retire(32'h100);
      idle((i == 0) ? 2 : (i == 1) ? 8 : 3);
      retire(32'h140);
    end
    read_chk("lat_cycles", 0, 1, 32'd16);
`ifdef PROF_MAX_LAT_EN
    read_chk("max_lat", 0, 3, 32'd9);
`else
    read_chk("max_lat", 0, 3, 32'd0);
`endif

    // asynchronous reset in the middle of a region
    retire(32'h100);
    retire(32'h100);
    read_chk("pre_rst_rd", 0, 0, 32'd4);
    chk("pre_rst_valid", {63'h0, rd_valid}, 64'h1);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_run", {63'h0, run}, 64'h0);
    chk("arst_rv", {63'h0, rd_valid}, 64'h0);
    chk("arst_rd", {32'h0, rd_data}, 64'h0);
    chk("arst_flags", {48'h0, ovf, ovl}, 64'h0);
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // random traffic
    for (int c = 0; c < N; c++) begin
      cfg_write(2'd0, 3'(c), 32'h200 + 32'h10 * $urandom_range(0, 15));
      cfg_write(2'd1, 3'(c), 32'h200 + 32'h10 * $urandom_range(0, 15));
    end
    cfg_write(2'd2, 3'd0, 32'h300);
    cfg_write(2'd3, 3'd0, 32'h310);
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 39);
      if (r == 0) wbk_pc = m_start;
      else if (r == 1) wbk_pc = ($urandom_range(0, 3) == 0) ? m_stop : m_start;
      else if (r < 14) wbk_pc = m_entry[$urandom_range(0, N-1)];
      else if (r < 28) wbk_pc = m_exit[$urandom_range(0, N-1)];
      else wbk_pc = 32'h1000 + 32'h4 * $urandom_range(0, 15);
      stall  = ($urandom_range(0, 3) == 0);
      rd_req = $urandom_range(0, 1);
      rd_ch  = 3'($urandom_range(0, 7));
      rd_sel = 2'($urandom_range(0, 3));
      cfg_we = ($urandom_range(0, 49) == 0);
      cfg_sel = 2'($urandom_range(0, 3));
      cfg_ch = 3'($urandom_range(0, 7));
      cfg_data = 32'h200 + 32'h10 * $urandom_range(0, 16);
      clr = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 99) == 0) ch_en = 8'($urandom);
      cyc();
    end
    cfg_we = 1'b0; clr = 1'b0; rd_req = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_region_profiler.md
Name: pc_region_profiler

Overview:
Parametrised multi-channel successor to the single-purpose FreeRTOS profiler. It watches the write-back PC and times up to N_CH software regions, each with a run-time programmable entry/exit PC pair, inside a global start/stop window. Per channel it keeps invocation counts and accumulated cycles, with saturation and misuse flags. It sits beside the core pipeline, fed from the write-back stage, and results are read over a simple request/valid port.

Parameters:
XLEN, 32, PC and read-data width
N_CH, 8, number of region channels (1..16)
CNT_W, 32, invocation counter width (<= XLEN)
ACC_W, 48, cycle accumulator width (XLEN < ACC_W <= 2*XLEN)
START_PC, 32'h0, reset value of the window start PC
STOP_PC, 32'h0, reset value of the window stop PC

Ports:
clk_i  in  1  single clock; all logic on posedge
rst_ni  in  1  asynchronous, active-low reset
stall_i  in  1  pipeline stall; a PC match is a retirement only when stall_i=0
wbk_pc_i  in  XLEN  write-back stage PC
cfg_we_i  in  1  config write strobe
cfg_ch_i  in  $clog2(N_CH)  config channel
cfg_sel_i  in  2  0=entry PC, 1=exit PC, 2=start PC (global), 3=stop PC (global)
cfg_data_i  in  XLEN  config data
ch_en_i  in  N_CH  per-channel enable
clr_i  in  1  synchronous clear of counters/flags/FSM
rd_req_i  in  1  read request
rd_ch_i  in  $clog2(N_CH)  read channel
rd_sel_i  in  2  0=count, 1=cycles[XLEN-1:0], 2=cycles[ACC_W-1:XLEN] zero-extended, 3=max latency
rd_valid_o  out  1  read data valid
rd_data_o  out  XLEN  read data
run_o  out  1  FSM in RUN
ovf_o  out  N_CH  sticky saturation flag
overlap_o  out  N_CH  sticky re-entry-while-active flag

Behaviour:
- Reset (rst_ni=0, async): FSM=IDLE, all counters/active flags/sticky flags=0, entry/exit PCs=0, start/stop PCs=START_PC/STOP_PC, rd_valid_o=0, rd_data_o=0, run_o=0.
- ret = !stall_i. start_hit = ret && wbk_pc_i==start_pc; similarly stop_hit, entry_hit[c], exit_hit[c].
- FSM: IDLE -start_hit-> RUN; RUN -stop_hit-> DONE; DONE -start_hit-> RUN (accumulates further); any state -clr_i-> IDLE. start_hit and stop_hit on the same cycle in RUN: stop wins. run_o is registered from the state.
- Active flag per enabled channel, tracked in every FSM state: set on entry_hit, cleared on exit_hit, both at the next edge. If entry_hit and exit_hit coincide: exit wins if active, entry wins if inactive. Disabled channel: active forced 0 next cycle.
- In RUN only: count[c]++ on entry_hit when inactive. cycles[c]++ on every cycle with active[c]=1. The exit-retire cycle is counted; the entry-retire cycle is not. Latency of one invocation = exit_cycle - entry_cycle.
- entry_hit while active: no count, active unchanged, overlap_o[c] set (any FSM state).
- Saturation: count and cycles stop at all-ones. The increment that would wrap sets ovf_o[c] instead.
- clr_i: counters, active flags, sticky flags and max-latency cleared; FSM to IDLE. Config registers retained. clr_i has priority over all same-cycle events.
- Config write is visible to matching from the next cycle. Write to cfg_sel 2/3 ignores cfg_ch_i.
- Read: rd_req_i at cycle T gives rd_valid_o=1 and rd_data_o at T+1 (registered, 1-cycle pulse), reflecting counter values at the T edge. Back-to-back requests are allowed. rd_data_o holds its value when rd_valid_o=0. Out-of-range rd_ch_i returns 0.
- Count is zero-extended to XLEN.

Optional Feature:
PROF_MAX_LAT_EN: when defined, each channel has an ACC_W-bit running-latency register, zeroed on entry and incremented with cycles. On exit_hit in RUN, max[c] <= max(max[c], running+1), so max[c] holds the largest single-invocation latency, truncated to XLEN on read; rd_sel 3 returns it. When undefined, none of this logic exists and rd_sel 3 reads 0.

Test Plan:
- Ch0 entry=0x100, exit=0x140, start=0x10, stop=0x20. Retire 0x10, then 0x100, then exit 5 cycles later -> count0=1, cycles0=5, run_o=1.
- Same region with stall_i=1 on the 0x100 match cycles, released later -> counting starts only from the unstalled match.
- Entry 0x100 retired twice without exit -> count0=1, overlap_o[0]=1; clr_i -> all zero, overlap_o=0, FSM IDLE.
- CNT_W=4 and 16 invocations -> count=15, ovf_o[c]=1.
- Region retired before start_hit and after stop_hit -> counters unchanged. Re-start from DONE -> accumulation resumes.
- Reads: rd_req on sel 0,1,2 back-to-back -> rd_valid on the three following cycles with the correct data. Assert rst_ni mid-region -> immediate zero outputs. With PROF_MAX_LAT_EN, latencies 3, 9, 4 -> rd_sel3 = 9.
